// File: rtl/clock_display_scan.sv
// Scans a 6-digit multiplexed 7-segment display showing HH:MM:SS, snapshotting the time once per frame.
// Optional feature: define BLANK_LEADING_ZERO_EN to blank the hours-tens digit when hours < 10.
module clock_display_scan #(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    output logic [6:0] seg,
    output logic [5:0] dig_en,
    output logic       frame_start
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    logic [DW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [4:0]    snap_h;
    logic [5:0]    snap_m;
    logic [5:0]    snap_s;
    logic          div_last;

    assign div_last = (div_cnt == DW'(SCAN_DIV - 1));

    // {tens, units} by comparing against multiples of ten; inputs never exceed 63
    function automatic logic [7:0] split_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] r;
        if (v >= 6'd50) begin
            t = 4'd5; r = v - 6'd50;
        end else if (v >= 6'd40) begin
            t = 4'd4; r = v - 6'd40;
        end else if (v >= 6'd30) begin
            t = 4'd3; r = v - 6'd30;
        end else if (v >= 6'd20) begin
            t = 4'd2; r = v - 6'd20;
        end else if (v >= 6'd10) begin
            t = 4'd1; r = v - 6'd10;
        end else begin
            t = 4'd0; r = v;
        end
        return {t, r[3:0]};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return SEG_BLANK;
        endcase
    endfunction

    logic [7:0] bcd_h, bcd_m, bcd_s;
    logic       bad_h, bad_m, bad_s;
    logic [6:0] seg_nxt;

    always_comb begin
        bcd_h = split_bcd({1'b0, snap_h});
        bcd_m = split_bcd(snap_m);
        bcd_s = split_bcd(snap_s);
        bad_h = (snap_h > 5'd23);
        bad_m = (snap_m > 6'd59);
        bad_s = (snap_s > 6'd59);
        seg_nxt = SEG_BLANK;
        case (idx)
            3'd0: seg_nxt = bad_s ? SEG_DASH : seg7(bcd_s[3:0]);
            3'd1: seg_nxt = bad_s ? SEG_DASH : seg7(bcd_s[7:4]);
            3'd2: seg_nxt = bad_m ? SEG_DASH : seg7(bcd_m[3:0]);
            3'd3: seg_nxt = bad_m ? SEG_DASH : seg7(bcd_m[7:4]);
            3'd4: seg_nxt = bad_h ? SEG_DASH : seg7(bcd_h[3:0]);
            3'd5: begin
                if (bad_h)
                    seg_nxt = SEG_DASH;
`ifdef BLANK_LEADING_ZERO_EN
                else if (snap_h < 5'd10)
                    seg_nxt = SEG_BLANK;
`endif
                else
                    seg_nxt = seg7(bcd_h[7:4]);
            end
            default: seg_nxt = SEG_BLANK;
        endcase
    end

    // Outputs are registered from the current idx/snap, so they trail the scan state by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            idx         <= '0;
            snap_h      <= '0;
            snap_m      <= '0;
            snap_s      <= '0;
            seg         <= SEG_BLANK;
            dig_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            if (div_last) begin
                div_cnt <= '0;
                if (idx == 3'd5) begin
                    idx    <= '0;
                    snap_h <= hours;
                    snap_m <= minutes;
                    snap_s <= seconds;
                end else begin
                    idx <= idx + 3'd1;
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            seg         <= seg_nxt;
            dig_en      <= 6'b1 << idx;
            frame_start <= (idx == 3'd0) && (div_cnt == '0);
        end
    end
endmodule

// File: tb/tb_clock_display_scan.sv
// Directed self-checking bench for clock_display_scan with SCAN_DIV=4 (24-cycle frame).
module tb_clock_display_scan;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [6:0] seg;
    logic [5:0] dig_en;
    logic       frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    clock_display_scan #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .hours(hours), .minutes(minutes), .seconds(seconds),
        .seg(seg), .dig_en(dig_en), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the next negedge where frame_start is high; ok=0 if it never shows
    task automatic sync_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [6:0] exp2 [6] = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
        rst = 1'b1; hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
        step(2);
        n_cmp++;
        if (seg !== 7'h00 || dig_en !== 6'h00 || frame_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_blank: got seg=%h dig_en=%h fs=%b want 00/00/0", seg, dig_en, frame_start);
        end
        rst = 1'b0;
        step(1);
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_bad++; $display("FAIL first_fs: got %b want 1", frame_start);
        end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (dig_en !== (6'h01 << k) || seg !== 7'h3F) begin
                n_bad++;
                $display("FAIL frame1_d%0d: got seg=%h dig_en=%h want 3f/%h", k, seg, dig_en, 6'h01 << k);
            end
            step(4);
        end
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_bad++; $display("FAIL frame2_fs: got %b want 1", frame_start);
        end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (dig_en !== (6'h01 << k) || seg !== exp2[k]) begin
                n_bad++;
                $display("FAIL frame2_d%0d: got seg=%h dig_en=%h want %h/%h", k, seg, dig_en, exp2[k], 6'h01 << k);
            end
            step(4);
        end
    endtask

    task automatic test_scan;
        bit ok;
        logic [5:0] exp_en;
        sync_frame(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL scan_sync: frame_start got 0 want 1 within 30 cycles");
        end
        for (int c = 0; c <= 24; c++) begin
            exp_en = 6'h01 << ((c % 24) / 4);
            n_cmp++;
            if (dig_en !== exp_en || frame_start !== ((c % 24) == 0)) begin
                n_bad++;
                $display("FAIL scan_c%0d: got dig_en=%h fs=%b want %h/%b", c, dig_en, frame_start, exp_en, (c % 24) == 0);
            end
            if (c < 24) step(1);
        end
    endtask

    task automatic test_snapshot;
        bit ok;
        logic [6:0] exp_rest [6] = '{7'h00, 7'h00, 7'h66, 7'h4F, 7'h5B, 7'h06};
        sync_frame(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL snap_sync: frame_start got 0 want 1 within 30 cycles");
        end
        step(8);
        seconds = 6'd57;
        for (int k = 2; k < 6; k++) begin
            n_cmp++;
            if (dig_en !== (6'h01 << k) || seg !== exp_rest[k]) begin
                n_bad++;
                $display("FAIL snap_hold_d%0d: got seg=%h dig_en=%h want %h/%h", k, seg, dig_en, exp_rest[k], 6'h01 << k);
            end
            step(4);
        end
        n_cmp++;
        if (frame_start !== 1'b1 || seg !== 7'h07) begin
            n_bad++; $display("FAIL snap_new_d0: got seg=%h fs=%b want 07/1", seg, frame_start);
        end
        step(4);
        n_cmp++;
        if (seg !== 7'h6D) begin
            n_bad++; $display("FAIL snap_new_d1: got %h want 6d", seg);
        end
    endtask

    task automatic test_range;
        bit ok;
        logic [6:0] exp_a [6];
        logic [6:0] exp_b [6] = '{7'h3F, 7'h3F, 7'h6F, 7'h6D, 7'h40, 7'h40};
`ifdef BLANK_LEADING_ZERO_EN
        exp_a = '{7'h6D, 7'h3F, 7'h40, 7'h40, 7'h6F, 7'h00};
`else
        exp_a = '{7'h6D, 7'h3F, 7'h40, 7'h40, 7'h6F, 7'h3F};
`endif
        hours = 5'd9; minutes = 6'd60; seconds = 6'd5;
        sync_frame(ok);
        step(24);
        n_cmp++;
        if (!ok || frame_start !== 1'b1) begin
            n_bad++; $display("FAIL range_sync: fs got %b want 1", frame_start);
        end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (seg !== exp_a[k]) begin
                n_bad++; $display("FAIL range_min_d%0d: got %h want %h", k, seg, exp_a[k]);
            end
            step(4);
        end
        hours = 5'd24; minutes = 6'd59; seconds = 6'd0;
        step(24);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (seg !== exp_b[k]) begin
                n_bad++; $display("FAIL range_hr_d%0d: got %h want %h", k, seg, exp_b[k]);
            end
            step(4);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        sync_frame(ok);
        step(12);
        n_cmp++;
        if (!ok || dig_en !== 6'h08) begin
            n_bad++; $display("FAIL rmid_pre: got dig_en=%h want 08", dig_en);
        end
        rst = 1'b1;
        step(1);
        n_cmp++;
        if (seg !== 7'h00 || dig_en !== 6'h00 || frame_start !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_blank: got seg=%h dig_en=%h fs=%b want 00/00/0", seg, dig_en, frame_start);
        end
        rst = 1'b0;
        step(1);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (seg !== 7'h3F || dig_en !== (6'h01 << k) || frame_start !== (k == 0)) begin
                n_bad++;
                $display("FAIL rmid_d%0d: got seg=%h dig_en=%h fs=%b want 3f/%h/%b", k, seg, dig_en, frame_start, 6'h01 << k, k == 0);
            end
            step(4);
        end
    endtask

    task automatic test_leading;
        bit ok;
        logic [6:0] exp5;
`ifdef BLANK_LEADING_ZERO_EN
        exp5 = 7'h00;
`else
        exp5 = 7'h3F;
`endif
        hours = 5'd7; minutes = 6'd0; seconds = 6'd0;
        sync_frame(ok);
        step(24 + 16);
        n_cmp++;
        if (!ok || seg !== 7'h07 || dig_en !== 6'h10) begin
            n_bad++; $display("FAIL lead_d4: got seg=%h dig_en=%h want 07/10", seg, dig_en);
        end
        step(4);
        n_cmp++;
        if (seg !== exp5 || dig_en !== 6'h20) begin
            n_bad++; $display("FAIL lead_d5: got seg=%h dig_en=%h want %h/20", seg, dig_en, exp5);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [6:0] exp [6] = '{7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h4F, 7'h5B};
        hours = 5'd23; minutes = 6'd59; seconds = 6'd59;
        sync_frame(ok);
        step(24);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (!ok || seg !== exp[k]) begin
                n_bad++; $display("FAIL max_d%0d: got %h want %h", k, seg, exp[k]);
            end
            step(4);
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_snapshot;
        test_range;
        test_reset_mid;
        test_leading;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
